// File: rtl/serial_mod_pkg.sv
// Shared types for the bit-serial modulus engine: FSM states and the worst-case
// accept-to-done latency.
package serial_mod_pkg;

  typedef enum logic [2:0] {IDLE, ALIGN, SUB, STEP, DONE} state_t;

  function automatic int MAX_LATENCY(input int width);
    return width * (width + 3) + 2;
  endfunction

endpackage

// File: rtl/bit_serial_sub.sv
// One-bit full subtractor with a registered borrow; clr zeroes the borrow so a
// fresh LSB-first pass starts clean.
module bit_serial_sub (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  logic brw_q, brw_d;

  assign diff   = a ^ b ^ brw_q;
  assign brw_d  = (~a & b) | (brw_q & ~(a ^ b));
  assign borrow = brw_q;

  always_ff @(posedge clk) begin
    if (rst || clr) brw_q <= 1'b0;
    else            brw_q <= brw_d;
  end

endmodule

// File: rtl/serial_mod_engine.sv
// Bit-serial remainder unit: aligns the divisor under the dividend, then
// restoring-subtracts one bit per cycle while shifting the divisor back down.
module serial_mod_engine
  import serial_mod_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rem,
  output logic             divisible,
  output logic             div_zero
);

  localparam int               IW   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, d_q, d_d, rem_q, rem_d;
  logic [IDX_W-1:0] sh_q, sh_d, idx_q, idx_d;
  logic             divisible_q, divisible_d, div_zero_q, div_zero_d;
  logic [WIDTH-1:0] dsh;
  logic             sub_diff, sub_brw, sub_clr;

  assign dsh     = d_q << sh_q;
  // Borrow is held clear outside SUB, so it is zero on every SUB entry and
  // still shows the final borrow during the first STEP cycle.
  assign sub_clr = (state_q != SUB);

  bit_serial_sub u_sub (
    .clk    (clk),
    .rst    (rst),
    .clr    (sub_clr),
    .a      (r_q[idx_q[IW-1:0]]),
    .b      (dsh[idx_q[IW-1:0]]),
    .diff   (sub_diff),
    .borrow (sub_brw)
  );

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    d_d         = d_q;
    sh_d        = sh_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    divisible_d = divisible_q;
    div_zero_d  = div_zero_q;
    case (state_q)
      IDLE: if (start) begin
        r_d         = dividend;
        d_d         = divisor;
        sh_d        = '0;
        idx_d       = '0;
        divisible_d = 1'b0;
        div_zero_d  = (divisor == '0);
        if (divisor == '0) begin
          state_d = DONE;
          rem_d   = dividend;
        end else if (dividend < divisor) begin
          state_d     = DONE;
          rem_d       = dividend;
          divisible_d = (dividend == '0);
        end else begin
          state_d = ALIGN;
        end
      end
      // Top bit of dsh clear guarantees the doubled compare loses nothing.
      ALIGN: if (!dsh[WIDTH-1] && ((dsh << 1) <= r_q)) begin
        sh_d = sh_q + IDX_W'(1);
      end else begin
        state_d = SUB;
        idx_d   = '0;
      end
      SUB: begin
        r_d[idx_q[IW-1:0]] = sub_diff;
        if (idx_q == LAST) state_d = STEP;
        else               idx_d   = idx_q + IDX_W'(1);
      end
      STEP: if (r_q >= dsh) begin
        state_d = SUB;
        idx_d   = '0;
      end else if (sh_q == '0) begin
        state_d     = DONE;
        rem_d       = r_q;
        divisible_d = (r_q == '0);
      end else begin
        sh_d = sh_q - IDX_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      d_q         <= '0;
      sh_q        <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      divisible_q <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      d_q         <= d_d;
      sh_q        <= sh_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      divisible_q <= divisible_d;
      div_zero_q  <= div_zero_d;
      if (state_q == STEP) assert (!sub_brw);
    end
  end

  assign ready     = (state_q == IDLE);
  assign busy      = ~ready;
  assign done      = (state_q == DONE);
  assign rem       = rem_q;
  assign divisible = divisible_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_serial_mod_engine.sv
// Scoreboard bench: drivers push expected results, per-DUT monitors pop and
// compare on every done pulse (WIDTH=9 and WIDTH=16 instances).
module tb_serial_mod_engine;
  import serial_mod_pkg::*;

  typedef struct {
    logic [15:0] rem;
    logic        dv;
    logic        dz;
    int          lat;   // exact latency, or -1 for bound-only
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       s9 = 1'b0;
  logic [8:0] a9 = '0, b9 = '0, rm9;
  logic       r9, bz9, dn9, dv9, dz9;
  logic        s16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, rm16;
  logic        r16, bz16, dn16, dv16, dz16;

  serial_mod_engine #(.WIDTH(9)) u9 (
    .clk(clk), .rst(rst), .start(s9), .dividend(a9), .divisor(b9),
    .ready(r9), .busy(bz9), .done(dn9), .rem(rm9), .divisible(dv9), .div_zero(dz9));

  serial_mod_engine #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(s16), .dividend(a16), .divisor(b16),
    .ready(r16), .busy(bz16), .done(dn16), .rem(rm16), .divisible(dv16), .div_zero(dz16));

  int total = 0, bad = 0, cyc = 0;
  exp_t q9[$], q16[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor for the WIDTH=9 engine
  initial begin
    int acc = 0;
    logic [8:0] hold = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (s9 && r9) acc = cyc;
        if (bz9 && !dn9) chk("rem9_stable", 32'(rm9), 32'(hold));
        if (dn9) begin
          chk("done9_expected", 32'(q9.size() > 0), 1);
          if (q9.size() > 0) begin
            e = q9.pop_front();
            chk("rem9", 32'(rm9), 32'(e.rem));
            chk("divisible9", 32'(dv9), 32'(e.dv));
            chk("div_zero9", 32'(dz9), 32'(e.dz));
            if (e.lat > 0) chk("lat9", 32'(cyc - acc + 1), 32'(e.lat));
            else chk("lat9_bound", 32'((cyc - acc + 1) <= MAX_LATENCY(9)), 1);
          end
        end
        if (r9) hold = rm9;
      end
    end
  end

  // Monitor for the WIDTH=16 engine
  initial begin
    int acc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (s16 && r16) acc = cyc;
        if (dn16) begin
          chk("done16_expected", 32'(q16.size() > 0), 1);
          if (q16.size() > 0) begin
            e = q16.pop_front();
            chk("rem16", 32'(rm16), 32'(e.rem));
            chk("divisible16", 32'(dv16), 32'(e.dv));
            chk("div_zero16", 32'(dz16), 32'(e.dz));
            if (e.lat > 0) chk("lat16", 32'(cyc - acc + 1), 32'(e.lat));
            else chk("lat16_bound", 32'((cyc - acc + 1) <= MAX_LATENCY(16)), 1);
          end
        end
      end
    end
  end

  task automatic wait_ready9(input int budget);
    int n = 0;
    while (!r9 && n < budget) begin @(posedge clk); #1; n++; end
    chk("ready9_timeout", 32'(r9), 1);
  endtask

  task automatic run9(input int a, input int b, input int er, input int edv,
                      input int edz, input int elat);
    exp_t e;
    wait_ready9(MAX_LATENCY(9) + 4);
    e.rem = 16'(er); e.dv = edv[0]; e.dz = edz[0]; e.lat = elat;
    q9.push_back(e);
    a9 = 9'(a); b9 = 9'(b); s9 = 1'b1;
    @(posedge clk); #1;
    s9 = 1'b0;
    wait_ready9(MAX_LATENCY(9) + 4);
  endtask

  task automatic run16(input int a, input int b, input int er, input int edv,
                       input int edz, input int elat);
    exp_t e;
    int n = 0;
    e.rem = 16'(er); e.dv = edv[0]; e.dz = edz[0]; e.lat = elat;
    q16.push_back(e);
    a16 = 16'(a); b16 = 16'(b); s16 = 1'b1;
    @(posedge clk); #1;
    s16 = 1'b0;
    while (!r16 && n < MAX_LATENCY(16) + 4) begin @(posedge clk); #1; n++; end
    chk("ready16_timeout", 32'(r16), 1);
  endtask

  initial begin
    int a, b, n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready9", 32'(r9), 1);
    chk("rst_busy9", 32'(bz9), 0);
    chk("rst_done9", 32'(dn9), 0);
    chk("rst_rem9", 32'(rm9), 0);
    chk("rst_divisible9", 32'(dv9), 0);
    chk("rst_div_zero9", 32'(dz9), 0);
    chk("rst_rem16", 32'(rm16), 0);
    @(posedge clk); #1;

    run9(503, 14, 13, 0, 0, -1);
    run9(511, 7, 0, 1, 0, -1);
    run9(77, 0, 77, 0, 1, 2);
    run9(5, 9, 5, 0, 0, 2);
    run9(0, 3, 0, 1, 0, 2);
    run9(9, 9, 0, 1, 0, -1);
    run9(511, 1, 0, 1, 0, -1);
    run16(65535, 1, 0, 1, 0, -1);
    run16(65535, 65534, 1, 0, 0, -1);

    // start held high for the whole operation: must be ignored while busy
    wait_ready9(MAX_LATENCY(9) + 4);
    begin
      exp_t e;
      e.rem = 16'd11; e.dv = 1'b0; e.dz = 1'b0; e.lat = -1;
      q9.push_back(e);
    end
    a9 = 9'd300; b9 = 9'd17; s9 = 1'b1;
    @(posedge clk); #1;
    a9 = 9'd6; b9 = 9'd4;
    n = 0;
    while (!dn9 && n < MAX_LATENCY(9) + 4) begin @(posedge clk); #1; n++; end
    chk("busy_start_done_seen", 32'(dn9), 1);
    s9 = 1'b0;
    @(posedge clk); #1;
    chk("busy_start_ready_after", 32'(r9), 1);
    repeat (3) @(posedge clk);
    #1 chk("busy_start_no_extra", 32'(q9.size()), 0);

    // reset during SUB aborts with no done pulse
    a9 = 9'd503; b9 = 9'd14; s9 = 1'b1;
    @(posedge clk); #1;
    s9 = 1'b0;
    n = 0;
    while (u9.state_q != SUB && n < 40) begin @(posedge clk); #1; n++; end
    chk("reached_sub", 32'(u9.state_q == SUB), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", 32'(r9), 1);
    chk("abort_rem", 32'(rm9), 0);
    chk("abort_done", 32'(dn9), 0);
    repeat (3) @(posedge clk);
    run9(100, 30, 10, 0, 0, -1);

    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(511, 0));
      b = (i % 8 == 0) ? 0 : int'($urandom_range((i % 3 == 0) ? 15 : 511, 1));
      if (b == 0) run9(a, b, a, 0, 1, 2);
      else run9(a, b, a % b, int'(a % b == 0), 0, (a < b) ? 2 : -1);
    end
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(65535, 0));
      b = int'($urandom_range((i < 3) ? 31 : 65535, 1));
      run16(a, b, a % b, int'(a % b == 0), 0, (a < b) ? 2 : -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("q9_drained", 32'(q9.size()), 0);
    chk("q16_drained", 32'(q16.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
